div5_appx_seq: RTL
==================

// Module: div5_appx_seq
// PURPOSE
//  Sequential restoring divider: the inverse companion of the team's 5-bit approximate multipliers.
//  Computes q = a / b and r = a % b, one quotient bit per cycle, under valid/ready handshakes.
//  Sits in the approximate functional-unit pool. Used for error-injection and accuracy studies
//  alongside the multiply units.
// PARAMETERS
//  WIDTH     5    operand, quotient and remainder width in bits (>= 2)
// PORTS
//  clk          in   1      single clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      operands a,b present
//  in_ready     out  1      block can accept operands
//  a            in   WIDTH  dividend, unsigned
//  b            in   WIDTH  divisor, unsigned
//  out_valid    out  1      result present
//  out_ready    in   1      consumer takes result
//  q            out  WIDTH  quotient
//  r            out  WIDTH  remainder
//  div_by_zero  out  1      result came from b==0
//  appx         out  1      divisor was altered by quantization (always 0 without macro)
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; q, r, div_by_zero and appx all 0.
//    Reset mid-operation aborts the operation and discards it. No output is produced.
//  - FSM IDLE -> CALC -> DONE -> IDLE:
//    IDLE: in_ready=1. On in_valid&in_ready, latch a and the effective divisor bd.
//      bd!=0 -> CALC with cnt=WIDTH-1.
//      bd==0 -> DONE directly.
//    CALC: one restoring step per cycle, MSB first:
//      partial remainder p = {p, a[cnt]}
//      if p >= bd: p -= bd and q[cnt]=1, else q[cnt]=0
//      leave after cnt==0
//    DONE: out_valid=1; q, r, div_by_zero and appx stable. On out_ready -> IDLE.
//  - in_ready=0 in CALC and DONE. No new operand is accepted until the result is taken,
//    so there is no simultaneous accept/complete.
//  - Latency: accept edge -> out_valid high after WIDTH+1 edges (6 at default).
//    Divide-by-zero: 1 edge.
//  - Throughput: the earliest next accept is the edge after the out handshake. One op per WIDTH+2 cycles.
//  - b==0: q = all ones, r = a, div_by_zero=1, appx=0.
//  - Width rules: p is WIDTH+1 bits internally. q and r never exceed WIDTH bits. r < bd always.
//  - Outputs hold in DONE while out_ready=0 (backpressure), for any number of cycles.
//  - in_valid asserted outside IDLE is ignored. a and b are sampled only at the accept edge.
// CONFIGURATION
//  DIV5_APPX_QUANT_EN defined:
//    bd = the largest value of form 2^k or 3*2^k that is <= b (e.g. 5->4, 7->6, 13->12, 25->24).
//    appx = (bd != b). q and r are exact relative to bd, so q >= the exact quotient.
//  DIV5_APPX_QUANT_EN undefined: bd = b, appx tied 0. The result is exact.
//  Latency and handshake are identical in both builds.
// STRUCTURE
//  div5_appx_pkg:
//    state enum {IDLE, CALC, DONE}
//    DBZ_Q constant (all ones)
//    count-width function clog2(WIDTH)
//  Sub-module div5_quant: combinational b -> bd and appx, with leading-one detect plus next-bit test.
//    Instantiated only under DIV5_APPX_QUANT_EN.
// TESTING
//  1. a=23, b=5:
//     exact -> q=4, r=3, appx=0
//     quant -> q=5, r=3, appx=1
//     out_valid exactly 6 edges after accept
//  2. a=31, b=7:
//     exact -> q=4, r=3
//     quant (bd=6) -> q=5, r=1, appx=1
//  3. a=9, b=0 -> after 1 edge: q=31, r=9, div_by_zero=1, appx=0
//  4. a=30, b=6, out_ready held low 4 cycles -> q=5, r=0 stable throughout.
//     in_ready stays 0. A new in_valid is ignored until the handshake.
//  5. Drop rst_n at the 3rd CALC cycle -> out_valid=0 and in_ready=1 immediately.
//     No result is emitted. The next op a=17, b=4 yields q=4, r=1.
//  6. Back-to-back ops with out_ready=1 and in_valid=1, against a random-vector model
//     (exact or quantized per build) -> every result matches, one op per 7 cycles.

Source files
------------

// File: rtl/div5_appx_pkg.sv
// Shared types and constants for the div5_appx_seq restoring divider.
package div5_appx_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    // Quotient reported for a zero divisor; sliced to WIDTH at the point of use.
    localparam logic [31:0] DBZ_Q = '1;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/div5_quant.sv
// Divisor quantizer: b -> largest 2^k or 3*2^k not above b. Compiled only when
// DIV5_APPX_QUANT_EN is defined, since only that build instantiates it.
`ifdef DIV5_APPX_QUANT_EN
module div5_quant #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] bd_o,
    output logic             appx_o
);

    logic [WIDTH-1:0] lead;

    always_comb begin
        lead = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b_i[i]) begin
                lead    = '0;
                lead[i] = 1'b1;
            end
        end
    end

    // Keep the leading one and the bit just below it; everything lower is dropped.
    assign bd_o   = b_i & (lead | (lead >> 1));
    assign appx_o = (bd_o != b_i);

endmodule
`endif

// File: rtl/div5_appx_seq.sv
// Sequential restoring divider (q = a / bd, r = a % bd), one quotient bit per cycle.
// Define DIV5_APPX_QUANT_EN to quantize the divisor through div5_quant.
module div5_appx_seq
    import div5_appx_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             appx
);

    localparam int CNT_W = clog2(WIDTH);

    logic [WIDTH-1:0] bd_w;
    logic             appx_w;

`ifdef DIV5_APPX_QUANT_EN
    div5_quant #(.WIDTH(WIDTH)) u_quant (
        .b_i    (b),
        .bd_o   (bd_w),
        .appx_o (appx_w)
    );
`else
    assign bd_w   = b;
    assign appx_w = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bd_q, bd_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] qv_q, qv_d;
    logic             dbz_q, dbz_d;
    logic             appx_q, appx_d;
    logic [WIDTH:0]   p_shift;
    logic             ge;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        bd_d    = bd_q;
        p_d     = p_q;
        qv_d    = qv_q;
        dbz_d   = dbz_q;
        appx_d  = appx_q;
        // p_q < bd_q always holds, so one extra bit suffices for the shifted value.
        p_shift = {p_q, a_q[cnt_q]};
        ge      = (p_shift >= {1'b0, bd_q});

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d  = a;
                    bd_d = bd_w;
                    if (bd_w == '0) begin
                        qv_d    = DBZ_Q[WIDTH-1:0];
                        p_d     = a;
                        dbz_d   = 1'b1;
                        appx_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        qv_d    = '0;
                        p_d     = '0;
                        dbz_d   = 1'b0;
                        appx_d  = appx_w;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                qv_d[cnt_q] = ge;
                if (ge) p_d = WIDTH'(p_shift - {1'b0, bd_q});
                else    p_d = p_shift[WIDTH-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            bd_q    <= '0;
            p_q     <= '0;
            qv_q    <= '0;
            dbz_q   <= 1'b0;
            appx_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            bd_q    <= bd_d;
            p_q     <= p_d;
            qv_q    <= qv_d;
            dbz_q   <= dbz_d;
            appx_q  <= appx_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign q           = qv_q;
    assign r           = p_q;
    assign div_by_zero = dbz_q;
    assign appx        = appx_q;

endmodule
